ysyx_23060201_gpr_sb: RTL and testbench

Parametrised general-purpose register file with an integrated per-register write scoreboard for the pipelined NPC core. It provides NREAD combinational read ports with a per-port ready flag, one writeback port, and an issue-side reservation port that counts outstanding writes per register. Decode uses it to detect RAW hazards and stall; writeback retires reservations. x0 is hardwired to zero and is never reserved.

---
 rtl/ysyx_23060201_gpr_pkg.sv | 19 +
 rtl/ysyx_23060201_gpr_pend_cnt.sv | 47 ++++
 rtl/ysyx_23060201_gpr_sb.sv | 92 +++++++++
 tb/tb_ysyx_23060201_gpr_sb.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060201_gpr_pkg.sv
// Shared definitions for the GPR file and its per-register pending-write scoreboard.
package ysyx_23060201_gpr_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 5;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned REG_ZERO       = 0;

   typedef enum logic [1:0] {
      PendHold,
      PendInc,
      PendDec,
      PendClr
   } pend_op_e;

   function automatic int unsigned pend_max(input int unsigned width);
      return (1 << width) - 1;
   endfunction

endpackage

// File: rtl/ysyx_23060201_gpr_pend_cnt.sv
// Saturating up/down counter tracking outstanding writes to one register.
module ysyx_23060201_gpr_pend_cnt
   import ysyx_23060201_gpr_pkg::*;
#(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);

   localparam logic [WIDTH-1:0] CntMax = WIDTH'(pend_max(WIDTH));

   logic [WIDTH-1:0] cnt_q;
   pend_op_e         op;

   // Simultaneous inc and dec cancel out; clear wins over both.
   always_comb begin
      op = PendHold;
      if (clr) begin
         op = PendClr;
      end else if (inc && !dec && cnt_q != CntMax) begin
         op = PendInc;
      end else if (dec && !inc && cnt_q != '0) begin
         op = PendDec;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         unique case (op)
            PendClr: cnt_q <= '0;
            PendInc: cnt_q <= cnt_q + WIDTH'(1);
            PendDec: cnt_q <= cnt_q - WIDTH'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_23060201_gpr_sb.sv
// GPR file with per-register write scoreboard; define GPR_BYPASS_EN to forward
// the same-cycle writeback to read ports.
module ysyx_23060201_gpr_sb
   import ysyx_23060201_gpr_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned NREAD      = 2,
   parameter int unsigned PEND_WIDTH = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NREAD-1:0]            rd_en,
   input  logic [NREAD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NREAD*DATA_WIDTH-1:0] rd_data,
   output logic [NREAD-1:0]            rd_ready,
   input  logic                        rsv_valid,
   input  logic [ADDR_WIDTH-1:0]       rsv_addr,
   output logic                        rsv_ready,
   input  logic                        wb_en,
   input  logic [ADDR_WIDTH-1:0]       wb_addr,
   input  logic [DATA_WIDTH-1:0]       wb_data,
   input  logic                        wb_retire,
   input  logic                        flush
);

   localparam int unsigned       DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [PEND_WIDTH-1:0] PendMax = PEND_WIDTH'(pend_max(PEND_WIDTH));
   localparam logic [ADDR_WIDTH-1:0] Zero    = ADDR_WIDTH'(REG_ZERO);

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [PEND_WIDTH-1:0] pend   [DEPTH];
   logic                  retire;
   logic                  rsv_fire;

   assign retire   = wb_en && wb_retire;
   assign rsv_fire = rsv_valid && rsv_ready;

   // A full counter can still take a reservation if a retire frees a slot this cycle.
   assign rsv_ready = !((pend[rsv_addr] == PendMax) && !(retire && wb_addr == rsv_addr));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wb_en && wb_addr != Zero) begin
         regs_q[wb_addr] <= wb_data;
      end
   end

   assign pend[0] = '0;

   for (genvar r = 1; r < DEPTH; r++) begin : g_pend
      ysyx_23060201_gpr_pend_cnt #(
         .WIDTH (PEND_WIDTH)
      ) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (rsv_fire && rsv_addr == ADDR_WIDTH'(r)),
         .dec   (retire && wb_addr == ADDR_WIDTH'(r)),
         .clr   (flush),
         .cnt   (pend[r])
      );
   end

   for (genvar p = 0; p < NREAD; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         rd_data[p*DATA_WIDTH +: DATA_WIDTH] = '0;
         rd_ready[p]                         = 1'b1;
         if (rd_en[p] && addr != Zero) begin
`ifdef GPR_BYPASS_EN
            if (wb_en && addr == wb_addr) begin
               rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wb_data;
               rd_ready[p] = (pend[addr] == '0) ||
                             (wb_retire && pend[addr] == PEND_WIDTH'(1));
            end else begin
               rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[addr];
               rd_ready[p]                         = (pend[addr] == '0);
            end
`else
            rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[addr];
            rd_ready[p]                         = (pend[addr] == '0);
`endif
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060201_gpr_sb.sv
// Directed self-checking bench for ysyx_23060201_gpr_sb (default parameters).
module tb_ysyx_23060201_gpr_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_ready;
   logic        rsv_valid;
   logic [4:0]  rsv_addr;
   logic        rsv_ready;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_retire;
   logic        flush;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   ysyx_23060201_gpr_sb dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_ready  (rd_ready),
      .rsv_valid (rsv_valid),
      .rsv_addr  (rsv_addr),
      .rsv_ready (rsv_ready),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .wb_retire (wb_retire),
      .flush     (flush)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rsv_valid = 1'b0;
      wb_en     = 1'b0;
      wb_retire = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic rd(input int p, input logic [4:0] a);
      rd_en[p]         = 1'b1;
      rd_addr[p*5 +: 5] = a;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic ret);
      wb_en     = 1'b1;
      wb_addr   = a;
      wb_data   = d;
      wb_retire = ret;
   endtask

   task automatic rsv(input logic [4:0] a);
      rsv_valid = 1'b1;
      rsv_addr  = a;
   endtask

   initial begin
      rst_n   = 1'b0;
      rd_en   = '0;
      rd_addr = '0;
      rsv_addr = '0;
      wb_addr = '0;
      wb_data = '0;
      idle();
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("post_reset_rsv_ready", 32'(rsv_ready), 32'd1);
      chk("post_reset_rd_ready", 32'(rd_ready), 32'd3);

      // Reset clears data and reservations.
      wb(5'd5, 32'h1234, 1'b0);
      rsv(5'd5);
      tick();
      idle();
      rd(0, 5'd5);
      #1;
      chk("x5_written", rd_data[31:0], 32'h1234);
      chk("x5_pending", 32'(rd_ready[0]), 32'd0);
      rst_n = 1'b0;
      wb(5'd5, 32'hBAD, 1'b0);
      tick();
      idle();
      rst_n = 1'b1;
      #1;
      chk("reset_x5_data", rd_data[31:0], 32'h0);
      chk("reset_x5_ready", 32'(rd_ready[0]), 32'd1);
      rsv_addr = 5'd5;
      #1;
      chk("reset_rsv_ready", 32'(rsv_ready), 32'd1);
      chk("rd_dis_data", rd_data[63:32], 32'h0);

      // Write then read, same-cycle read sees old data without bypass.
      wb(5'd3, 32'hDEADBEEF, 1'b0);
      tick();
      idle();
      rd(0, 5'd3);
      #1;
      chk("x3_read", rd_data[31:0], 32'hDEADBEEF);
      wb(5'd3, 32'h11111111, 1'b0);
      #1;
`ifdef GPR_BYPASS_EN
      chk("x3_same_cycle", rd_data[31:0], 32'h11111111);
`else
      chk("x3_same_cycle", rd_data[31:0], 32'hDEADBEEF);
`endif
      tick();
      idle();
      chk("x3_next_cycle", rd_data[31:0], 32'h11111111);
      wb(5'd0, 32'hFFFFFFFF, 1'b0);
      rd(1, 5'd0);
      tick();
      idle();
      chk("x0_data", rd_data[63:32], 32'h0);
      chk("x0_ready", 32'(rd_ready[1]), 32'd1);

      // RAW hazard.
      rsv(5'd7);
      tick();
      idle();
      rd(1, 5'd7);
      #1;
      chk("x7_hazard", 32'(rd_ready[1]), 32'd0);
      wb(5'd7, 32'h55, 1'b1);
      tick();
      idle();
      chk("x7_ready", 32'(rd_ready[1]), 32'd1);
      chk("x7_data", rd_data[63:32], 32'h55);

      // Saturation at 3 outstanding.
      for (int k = 0; k < 3; k++) begin
         rsv(5'd9);
         #1;
         chk("x9_rsv_ready_fill", 32'(rsv_ready), 32'd1);
         tick();
      end
      idle();
      rsv_addr = 5'd9;
      #1;
      chk("x9_full", 32'(rsv_ready), 32'd0);
      rsv_addr = 5'd10;
      #1;
      chk("x10_free", 32'(rsv_ready), 32'd1);
      rsv(5'd9);
      wb(5'd9, 32'h99, 1'b1);
      #1;
      chk("x9_rsv_retire_ready", 32'(rsv_ready), 32'd1);
      tick();
      idle();
      rsv_addr = 5'd9;
      #1;
      chk("x9_still_full", 32'(rsv_ready), 32'd0);
      // Drain 3, then one extra retire must not wrap.
      for (int k = 0; k < 4; k++) begin
         wb(5'd9, 32'h99, 1'b1);
         tick();
      end
      idle();
      rd(0, 5'd9);
      #1;
      chk("x9_drained", 32'(rd_ready[0]), 32'd1);
      rsv(5'd9);
      tick();
      idle();
      chk("x9_one_pending", 32'(rd_ready[0]), 32'd0);
      wb(5'd9, 32'h99, 1'b1);
      tick();
      idle();
      chk("x9_clear", 32'(rd_ready[0]), 32'd1);

      // Flush clears counters, writeback still commits.
      rsv(5'd4);
      tick();
      rsv(5'd6);
      tick();
      idle();
      rd(0, 5'd4);
      rd(1, 5'd6);
      #1;
      chk("flush_pre", 32'(rd_ready), 32'd0);
      flush = 1'b1;
      wb(5'd4, 32'h77, 1'b1);
      tick();
      idle();
      chk("flush_ready", 32'(rd_ready), 32'd3);
      chk("flush_x4_data", rd_data[31:0], 32'h77);
      flush = 1'b1;
      rsv(5'd4);
      tick();
      idle();
      chk("flush_over_rsv", 32'(rd_ready[0]), 32'd1);

      // Same-cycle writeback visibility with one outstanding write.
      wb(5'd8, 32'h3C, 1'b0);
      tick();
      idle();
      rsv(5'd8);
      tick();
      idle();
      rd(0, 5'd8);
      wb(5'd8, 32'hA5, 1'b1);
      #1;
`ifdef GPR_BYPASS_EN
      chk("bypass_data", rd_data[31:0], 32'hA5);
      chk("bypass_ready", 32'(rd_ready[0]), 32'd1);
`else
      chk("bypass_data", rd_data[31:0], 32'h3C);
      chk("bypass_ready", 32'(rd_ready[0]), 32'd0);
`endif
      tick();
      idle();
      chk("x8_after", rd_data[31:0], 32'hA5);
      chk("x8_ready_after", 32'(rd_ready[0]), 32'd1);

      // Mid-operation reset drops pending state.
      rsv(5'd12);
      tick();
      tick();
      idle();
      rd(1, 5'd12);
      #1;
      chk("x12_pending", 32'(rd_ready[1]), 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("x12_reset_ready", 32'(rd_ready[1]), 32'd1);
      chk("x8_reset_data", rd_data[31:0], 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
